// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: decoded op codes,
// FSM state encoding and a small op-decode helper.
package div_unit_pkg;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/div_unit_signfix.sv
// Final result shaping for the divider: applies the divide-by-zero
// result convention and restores operand signs for signed divides.
module div_signfix
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dividend_raw,
    input  logic             sign_en,
    input  logic             quo_neg,
    input  logic             rem_neg,
    input  logic             dz,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    // Divide-by-zero bypasses sign fixing entirely; the dividend is passed through unmodified.
    always_comb begin
        lo = quo;
        hi = rem;
        if (dz) begin
            lo = '1;
            hi = dividend_raw;
        end else if (sign_en) begin
            if (quo_neg) lo = -quo;
            if (rem_neg) hi = -rem;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   DIV_IDLE | waiting for a divide op in E; start latches operands
//   DIV_BUSY | one quotient bit per cycle, ITER cycles
//   DIV_DONE | div_ready high for one cycle, E advances at end of cycle
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       alucontrolE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             flushE,
    output logic             stall_div,
    output logic             div_ready,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             sign_en_q, sign_en_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dz_q, dz_d;
    logic             ready_q, ready_d;

    logic             start;
    logic             last_iter;
    logic             start_signed;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] iter_rem, iter_quo;
    logic [WIDTH-1:0] fix_lo, fix_hi;

    assign start     = is_div_op(alucontrolE) && (state_q == DIV_IDLE) && !flushE;
    assign last_iter = (state_q == DIV_BUSY) && (cnt_q == CNT_LAST);
    assign stall_div = !flushE && (start || (state_q == DIV_BUSY));
    assign div_ready = ready_q;
    assign div_hi    = hi_q;
    assign div_lo    = lo_q;

    // One restoring step: shift {rem, quo} left and keep the difference if it did not borrow.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        iter_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        iter_quo = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    div_signfix #(.WIDTH(WIDTH)) u_signfix (
        .quo          (iter_quo),
        .rem          (iter_rem),
        .dividend_raw (a_raw_q),
        .sign_en      (sign_en_q),
        .quo_neg      (quo_neg_q),
        .rem_neg      (rem_neg_q),
        .dz           (dz_q),
        .lo           (fix_lo),
        .hi           (fix_hi)
    );

    // Next-state and datapath update; a flush overrides everything and leaves hi/lo untouched.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvs_d        = dvs_q;
        a_raw_d      = a_raw_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        sign_en_d    = sign_en_q;
        quo_neg_d    = quo_neg_q;
        rem_neg_d    = rem_neg_q;
        dz_d         = dz_q;
        ready_d      = 1'b0;
        start_signed = (alucontrolE == EXE_DIV_OP);

        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    sign_en_d = start_signed;
                    quo_d     = (start_signed && srcaE[WIDTH-1]) ? -srcaE : srcaE;
                    dvs_d     = (start_signed && srcbE[WIDTH-1]) ? -srcbE : srcbE;
                    a_raw_d   = srcaE;
                    quo_neg_d = srcaE[WIDTH-1] ^ srcbE[WIDTH-1];
                    rem_neg_d = srcaE[WIDTH-1];
                    dz_d      = (srcbE == '0);
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                rem_d = iter_rem;
                quo_d = iter_quo;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = DIV_DONE;
                    hi_d    = fix_hi;
                    lo_d    = fix_lo;
                    ready_d = 1'b1;
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        if (flushE) begin
            state_d = DIV_IDLE;
            ready_d = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers; reset aborts any division immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            a_raw_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            sign_en_q <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            a_raw_q   <= a_raw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            sign_en_q <= sign_en_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            ready_q   <= ready_d;
        end
    end

endmodule
